// File: rtl/ct_f_spsram_param_if.sv
// rtl/ct_f_spsram_param_if.sv - macro-style single-port SRAM access bundle
interface ct_f_spsram_param_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;
    logic                  INIT_DONE;

    modport master (output A, CEN, GWEN, WEN, D, input Q, INIT_DONE);
    modport slave  (input A, CEN, GWEN, WEN, D, output Q, INIT_DONE);
endinterface

// File: rtl/ct_f_spsram_param.sv
// rtl/ct_f_spsram_param.sv - parametrised single-port SRAM with segment mask, optional output stage and zero sweep
module ct_f_spsram_param #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 128,
    parameter int SEG_WIDTH  = 8,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                CLK,
    input  logic                RST_B,
    ct_f_spsram_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NSEG  = DATA_WIDTH / SEG_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {INIT, CLEAR, READY} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  clear_we;
    logic                  init_done;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wen_unused;

    // only the MSB of each WEN segment is meaningful
    assign wen_unused = ^bus.WEN;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = (INIT_CLEAR != 0) ? CLEAR : READY;
            CLEAR:   if (cnt == CNT_LAST) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        clear_we  = 1'b0;
        init_done = 1'b0;
        case (state)
            CLEAR:   clear_we  = 1'b1;
            READY:   init_done = 1'b1;
            default: ;
        endcase
    end

    assign rd_en = init_done && !bus.CEN &&  bus.GWEN;
    assign wr_en = init_done && !bus.CEN && !bus.GWEN;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            cnt <= '0;
        end else if (clear_we) begin
            cnt <= cnt + 1'b1;
        end
    end

    // array itself is never reset; only the sweep or user writes change it
    always_ff @(posedge CLK) begin
        if (clear_we) begin
            mem[cnt[ADDR_WIDTH-1:0]] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NSEG; i++) begin
                if (!bus.WEN[i*SEG_WIDTH + SEG_WIDTH - 1]) begin
                    mem[bus.A][i*SEG_WIDTH +: SEG_WIDTH] <= bus.D[i*SEG_WIDTH +: SEG_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[bus.A];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  rd_vld;
            logic [DATA_WIDTH-1:0] q_pipe;

            // stage 2 follows stage 1 only after a real load, keeping Q's hold semantics
            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    rd_vld <= 1'b0;
                    q_pipe <= '0;
                end else begin
                    rd_vld <= rd_en;
                    if (rd_vld) q_pipe <= rd_q;
                end
            end
            assign bus.Q = q_pipe;
        end else begin : g_no_out_reg
            assign bus.Q = rd_q;
        end
    endgenerate

    assign bus.INIT_DONE = init_done;
endmodule

// File: tb/tb_ct_f_spsram_param.sv
// tb/tb_ct_f_spsram_param.sv - self-checking bench for ct_f_spsram_param (OUT_REG 0 and 1 side by side)
module tb_ct_f_spsram_param;
    localparam int AW    = 4;
    localparam int DW    = 128;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int             e;
        logic [DW-1:0]  d;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic [AW-1:0] a = '0;
    logic          cen = 1'b1;
    logic          gwen = 1'b1;
    logic [DW-1:0] wen = '1;
    logic [DW-1:0] d = '0;

    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;
    int            rel_edges = 0;
    logic [DW-1:0] mem_m [DEPTH];
    rd_t           hist [$];

    ct_f_spsram_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    ct_f_spsram_param_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    assign if0.A = a;   assign if0.CEN = cen; assign if0.GWEN = gwen; assign if0.WEN = wen; assign if0.D = d;
    assign if1.A = a;   assign if1.CEN = cen; assign if1.GWEN = gwen; assign if1.WEN = wen; assign if1.D = d;

    ct_f_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(8), .OUT_REG(0), .INIT_CLEAR(1))
        u0 (.CLK(clk), .RST_B(rst_b), .bus(if0));
    ct_f_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEG_WIDTH(8), .OUT_REG(1), .INIT_CLEAR(1))
        u1 (.CLK(clk), .RST_B(rst_b), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Q of a pipeline with given extra lag = most recent read whose edge is at least lag edges old
    function automatic logic [DW-1:0] exp_q(input int lag);
        logic [DW-1:0] r = '0;
        foreach (hist[i]) if (hist[i].e <= edge_n - lag) r = hist[i].d;
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        logic [DW-1:0] exp_done;
        exp_done = DW'(rst_b && (rel_edges >= DEPTH + 1));
        chk({tag, "_q0"}, if0.Q, exp_q(0));
        chk({tag, "_q1"}, if1.Q, exp_q(1));
        chk({tag, "_done0"}, DW'(if0.INIT_DONE), exp_done);
        chk({tag, "_done1"}, DW'(if1.INIT_DONE), exp_done);
    endtask

    task automatic step(input string tag, input logic c, input logic g, input logic [AW-1:0] ad,
                        input logic [DW-1:0] w, input logic [DW-1:0] dd);
        logic ready;
        ready = rst_b && (rel_edges >= DEPTH + 1);
        a = ad; cen = c; gwen = g; wen = w; d = dd;
        @(posedge clk);
        #1;
        if (rst_b) begin
            edge_n++;
            rel_edges++;
            if (ready && !c) begin
                if (g) begin
                    hist.push_back('{e: edge_n, d: mem_m[ad]});
                end else begin
                    for (int s = 0; s < DW / 8; s++)
                        if (!w[s*8 + 7]) mem_m[ad][s*8 +: 8] = dd[s*8 +: 8];
                end
            end
        end
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b1, 1'b1, '0, '1, '0);
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] ad);
        step(tag, 1'b0, 1'b1, ad, '1, '0);
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] ad, input logic [DW-1:0] w, input logic [DW-1:0] dd);
        step(tag, 1'b0, 1'b0, ad, w, dd);
    endtask

    task automatic assert_reset(input string tag);
        rst_b = 1'b0;
        #1;
        hist.delete();
        chk({tag, "_q0"}, if0.Q, '0);
        chk({tag, "_q1"}, if1.Q, '0);
        chk({tag, "_done0"}, DW'(if0.INIT_DONE), '0);
        chk({tag, "_done1"}, DW'(if1.INIT_DONE), '0);
        idle({tag, "_hold"});
        idle({tag, "_hold"});
        rst_b = 1'b1;
        rel_edges = 0;
        // the sweep leaves every word zero before any access is honoured
        foreach (mem_m[i]) mem_m[i] = '0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            idle(tag);
            chk({tag, "_low"}, DW'(if0.INIT_DONE), '0);
        end
        idle(tag);
        chk({tag, "_high"}, DW'(if0.INIT_DONE), DW'(1));
    endtask

    logic [DW-1:0] d5, d6, d7, wrnd, drnd;

    initial begin
        idle("reset_hold");
        assert_reset("reset");

        // access attempts during the sweep must be ignored
        for (int i = 0; i < 4; i++) idle("init");
        wr("init_wr", 4'd2, '0, '1);
        rd("init_rd", 4'd2);
        for (int i = 6; i < DEPTH; i++) idle("init");
        idle("init_last");
        chk("init_done_17", DW'(if0.INIT_DONE), DW'(1));

        for (int i = 0; i < DEPTH; i++) begin
            rd("zero_rd", AW'(i));
            chk("zero_q0", if0.Q, '0);
        end
        rd("init_wr_ignored", 4'd2);
        chk("init_wr_ignored_q", if0.Q, '0);

        // segment mask: only bytes 0 and 15 enabled
        wen = '1;
        wr("mask_wr", 4'd4, ~((DW'(1) << 127) | (DW'(1) << 7)), {16{8'hA5}});
        rd("mask_rd", 4'd4);
        chk("mask_q", if0.Q, {8'hA5, {14{8'h00}}, 8'hA5});

        // hold behaviour and no Q update on write
        wr("hold_wr11", 4'd3, '0, {16{8'h11}});
        rd("hold_rd", 4'd3);
        for (int i = 0; i < 5; i++) idle("hold_idle");
        wr("hold_wr22", 4'd3, '0, {16{8'h22}});
        chk("hold_q_after_wr", if0.Q, {16{8'h11}});
        rd("hold_rd2", 4'd3);
        chk("hold_new", if0.Q, {16{8'h22}});
        idle("hold_idle2");

        // OUT_REG=1 latency and streaming
        d5 = {4{32'h5555_0005}}; d6 = {4{32'h6666_0006}}; d7 = {4{32'h7777_0007}};
        wr("lat_wr5", 4'd5, '0, d5);
        wr("lat_wr6", 4'd6, '0, d6);
        wr("lat_wr7", 4'd7, '0, d7);
        rd("lat_rd5", 4'd5);
        chk("lat_t1_not_yet", if1.Q, {16{8'h22}});
        rd("lat_rd6", 4'd6);
        chk("lat_t2_d5", if1.Q, d5);
        rd("lat_rd7", 4'd7);
        chk("lat_t3_d6", if1.Q, d6);
        idle("lat_idle");
        chk("lat_t4_d7", if1.Q, d7);
        idle("lat_idle2");

        // randomized traffic against the reference model
        for (int n = 0; n < 300; n++) begin
            wrnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            drnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            step("rand", ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, DEPTH - 1)), wrnd, drnd);
        end

        // reset with Q likely non-zero, then abort a sweep at count 7
        rd("pre_rst_rd", 4'd7);
        idle("pre_rst_idle");
        assert_reset("rst_rand");
        for (int i = 0; i < 8; i++) idle("mid_sweep");
        assert_reset("rst_mid");
        sweep("resweep");
        for (int i = 0; i < DEPTH; i += 5) begin
            rd("resweep_rd", AW'(i));
            chk("resweep_zero", if0.Q, '0);
        end
        idle("end_idle");
        idle("end_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ct_f_spsram_param.md
# ct_f_spsram_param

Parametrised FPGA single-port SRAM model, the generalised successor of the fixed-size `ct_f_spsram_*` wrappers. It implements the same macro-style interface (`CEN`, `GWEN`, active-low bit `WEN`, registered `Q`) for any depth and width. It adds:
- true segment-granular write masking;
- an optional output pipeline register;
- a post-reset zero-initialisation sweep with a done flag.

It sits under cache/TLB array wrappers in the FPGA build wherever an ASIC SRAM macro is used in silicon.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: address bits; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 128: data bits; must be a multiple of `SEG_WIDTH`.
- `SEG_WIDTH`, 8: write-mask granularity; NSEG = DATA_WIDTH/SEG_WIDTH.
- `OUT_REG`, 0: 1 adds one output pipeline stage.
- `INIT_CLEAR`, 1: 1 enables the post-reset zero sweep.

Ports:
- `CLK`  in  1: clock. One clock only; all logic is on its rising edge.
- `RST_B`  in  1: asynchronous, active-low reset.
- `A`  in  ADDR_WIDTH: address.
- `CEN`  in  1: chip enable, active low.
- `GWEN`  in  1: global write enable, active low.
- `WEN`  in  DATA_WIDTH: bit write enable, active low.
- `D`  in  DATA_WIDTH: write data.
- `Q`  out  DATA_WIDTH: read data.
- `INIT_DONE`  out  1: high once the array is usable.

## Operation
- Access types:
  - Write cycle: `CEN`=0, `GWEN`=0, `INIT_DONE`=1.
  - Read cycle: `CEN`=0, `GWEN`=1, `INIT_DONE`=1.
  - Idle: `CEN`=1.
- Segment mask: segment i (bits [i*SEG_WIDTH +: SEG_WIDTH]) is written iff `WEN[i*SEG_WIDTH+SEG_WIDTH-1]`=0. Other `WEN` bits in the segment are ignored. All-ones `WEN` with `GWEN`=0 is a legal no-op write.
- Read port: memory read data is registered into the output data register `rd_q` on read cycles only.
- `Q` hold behaviour: `rd_q` holds its value on idle and write cycles, so `Q` keeps the last read result indefinitely.
- Read-during-write: not applicable, since the block is single-port. A write never changes `Q`, even when the write targets the last-read address.
- Init FSM states: `INIT`, `CLEAR`, `READY`.
  - Reset forces `INIT` and sets the clear counter to 0.
  - `INIT` → `CLEAR` on the first clock after reset release if INIT_CLEAR=1, otherwise → `READY`.
  - `CLEAR` writes all-zero to `mem[cnt]` each cycle and increments `cnt`.
  - Moves to `READY` in the cycle after the write to address 2^ADDR_WIDTH-1.
  - `READY` is terminal until the next reset.
- `INIT_DONE` = 1 only in `READY`.
- User accesses while `INIT_DONE`=0 are ignored entirely: no write, no `Q` update.
- Reset asserted mid-sweep aborts the sweep and restarts from address 0 after release. Memory contents are not otherwise touched by reset.
- INIT_CLEAR=0: array contents after configuration are undefined (X in simulation, bitstream init on FPGA).
- Counter width is ADDR_WIDTH+1 so the terminal condition has no wrap ambiguity.

## Timing
- Reset values:
  - `Q` = 0, and the output pipeline register (if OUT_REG=1) = 0.
  - `INIT_DONE` = 0.
  - FSM in `INIT`, `cnt` = 0.
- `INIT_DONE` rise:
  - INIT_CLEAR=1: rises exactly 2^ADDR_WIDTH+1 rising edges after the first edge with `RST_B`=1.
  - INIT_CLEAR=0: rises after 1 edge.
- Read latency: `Q` valid 1 cycle after the read cycle's edge when OUT_REG=0, 2 cycles when OUT_REG=1.
- With OUT_REG=1 the stage-2 register updates only when stage 1 was loaded in the previous cycle, so the hold behaviour of `Q` is preserved.
- Writes commit at the edge of the write cycle. A read of the same address in the next cycle returns the new data.
- Back-to-back reads sustain one per cycle. There is no stall or back-pressure.

## Test plan
- **Reset/init** (ADDR_WIDTH=4, INIT_CLEAR=1):
  - Release reset; `INIT_DONE` must be 0 for 16 edges and 1 from the 17th edge on.
  - Read all 16 addresses; every `Q` must be 0.
- **Masked write:**
  - Write `D`=all 0xA5 bytes with `WEN`=all 1s except segment 0 and segment 15 MSBs low.
  - Read back: only bytes 0 and 15 are 0xA5, all others are 0.
- **Hold and no-update-on-write:**
  - Read address 3 (data 0x11..), then idle 5 cycles, then write 0x22.. to address 3.
  - `Q` stays 0x11.. throughout; the next read of address 3 gives 0x22..
- **Latency:** with OUT_REG=1, a read of address 5 issued at cycle T shows its data at `Q` at T+2 and not at T+1; back-to-back reads of 5, 6, 7 stream out on consecutive cycles.
- **Access during init:**
  - Issue a write of 0xFF.. to address 2 while `INIT_DONE`=0.
  - After `INIT_DONE`, a read of address 2 returns 0 and `Q` was never disturbed.
- **Reset mid-sweep:**
  - Assert `RST_B` low at sweep count 7; `Q` and `INIT_DONE` go 0 immediately.
  - After release the full 2^ADDR_WIDTH+1-edge sweep repeats.
